// File: rtl/gpr_csr_file.sv
// NPC integer register file with machine-mode CSR unit.
// Combinational reads, posedge writes, 64-bit cycle/instret counters.
module gpr_csr_file #(
  parameter int          XLEN      = 32,
  parameter int          NREG      = 32,
  parameter int          NRD       = 2,
  parameter bit          BYPASS    = 1'b1,
  parameter logic [31:0] MVENDORID = 32'h79737978,
  parameter logic [31:0] MARCHID   = 32'h017eb18f,
  localparam int         AW        = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wen,
  input  logic [AW-1:0]        waddr,
  input  logic [XLEN-1:0]      wdata,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*XLEN-1:0]  rdata,
  input  logic [1:0]           csr_op,
  input  logic [11:0]          csr_addr,
  input  logic [XLEN-1:0]      csr_wdata,
  output logic [XLEN-1:0]      csr_rdata,
  output logic                 csr_illegal,
  input  logic                 retire,
  input  logic                 trap_valid,
  input  logic [XLEN-1:0]      trap_cause,
  input  logic [XLEN-1:0]      trap_pc,
  input  logic                 mret,
  output logic [XLEN-1:0]      mtvec_o,
  output logic [XLEN-1:0]      mepc_o,
  output logic [NREG*XLEN-1:0] dbg_x
);

  localparam logic [2*XLEN-1:0] ONE = 1;

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (wen && waddr != '0) regs[waddr] <= wdata;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr[i*AW +: AW];
    assign rdata[i*XLEN +: XLEN] =
      (ra == '0) ? '0 :
      (BYPASS && wen && waddr == ra) ? wdata :
      regs[ra];
  end

  for (genvar i = 0; i < NREG; i++) begin : g_dbg
    if (i == 0) begin : g_zero
      assign dbg_x[XLEN-1:0] = '0;
    end else begin : g_reg
      assign dbg_x[i*XLEN +: XLEN] = regs[i];
    end
  end

  logic            mie, mpie;
  logic [XLEN-1:2] mtvec_q, mepc_q;
  logic [XLEN-1:0] mscratch, mcause;
  logic [2*XLEN-1:0] mcycle, minstret;
  logic [XLEN-1:0] mstatus_v;

  assign mstatus_v = XLEN'({2'b11, 3'b0, mpie, 3'b0, mie, 3'b0});
  assign mtvec_o   = {mtvec_q, 2'b00};
  assign mepc_o    = {mepc_q, 2'b00};

  logic a_mstatus, a_mtvec, a_mscratch, a_mepc, a_mcause;
  logic a_mcycle, a_mcycleh, a_minstret, a_minstreth;
  logic a_mvendorid, a_marchid;

  assign a_mstatus   = csr_addr == 12'h300;
  assign a_mtvec     = csr_addr == 12'h305;
  assign a_mscratch  = csr_addr == 12'h340;
  assign a_mepc      = csr_addr == 12'h341;
  assign a_mcause    = csr_addr == 12'h342;
  assign a_mcycle    = csr_addr == 12'hB00;
  assign a_mcycleh   = csr_addr == 12'hB80;
  assign a_minstret  = csr_addr == 12'hB02;
  assign a_minstreth = csr_addr == 12'hB82;
  assign a_mvendorid = csr_addr == 12'hF11;
  assign a_marchid   = csr_addr == 12'hF12;

  logic [XLEN-1:0] csr_cur, csr_new;
  logic            csr_hit, csr_we, wr;

  always_comb begin
    csr_cur = '0;
    csr_hit = 1'b1;
    unique case (1'b1)
      a_mstatus:   csr_cur = mstatus_v;
      a_mtvec:     csr_cur = mtvec_o;
      a_mscratch:  csr_cur = mscratch;
      a_mepc:      csr_cur = mepc_o;
      a_mcause:    csr_cur = mcause;
      a_mcycle:    csr_cur = mcycle[XLEN-1:0];
      a_mcycleh:   csr_cur = mcycle[2*XLEN-1:XLEN];
      a_minstret:  csr_cur = minstret[XLEN-1:0];
      a_minstreth: csr_cur = minstret[2*XLEN-1:XLEN];
      a_mvendorid: csr_cur = XLEN'(MVENDORID);
      a_marchid:   csr_cur = XLEN'(MARCHID);
      default:     csr_hit = 1'b0;
    endcase
  end

  always_comb begin
    csr_new = csr_wdata;
    case (csr_op)
      2'b10:   csr_new = csr_cur | csr_wdata;
      2'b11:   csr_new = csr_cur & ~csr_wdata;
      default: csr_new = csr_wdata;
    endcase
  end

  // RS/RC with a zero mask are pure reads
  assign csr_we      = (csr_op == 2'b01) ||
                       (csr_op[1] && csr_wdata != '0);
  assign csr_illegal = (csr_op != 2'b00) &&
                       (!csr_hit || (csr_we && (a_mvendorid || a_marchid)));
  assign csr_rdata   = (csr_op != 2'b00) ? csr_cur : '0;
  assign wr          = csr_we && !csr_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec_q  <= '0;
      mepc_q   <= '0;
      mscratch <= '0;
      mcause   <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (wr && a_mcycle)       mcycle[XLEN-1:0] <= csr_new;
      else if (wr && a_mcycleh) mcycle[2*XLEN-1:XLEN] <= csr_new;
      else                      mcycle <= mcycle + ONE;

      if (wr && a_minstret)       minstret[XLEN-1:0] <= csr_new;
      else if (wr && a_minstreth) minstret[2*XLEN-1:XLEN] <= csr_new;
      else if (retire)            minstret <= minstret + ONE;

      if (wr && a_mtvec)    mtvec_q  <= csr_new[XLEN-1:2];
      if (wr && a_mscratch) mscratch <= csr_new;

      // trap and mret own mstatus/mepc/mcause at this edge
      if (trap_valid) begin
        mepc_q <= trap_pc[XLEN-1:2];
        mcause <= trap_cause;
        mpie   <= mie;
        mie    <= 1'b0;
      end else if (mret) begin
        mie    <= mpie;
        mpie   <= 1'b1;
      end else if (wr) begin
        if (a_mstatus) begin
          mie  <= csr_new[3];
          mpie <= csr_new[7];
        end
        if (a_mepc)   mepc_q <= csr_new[XLEN-1:2];
        if (a_mcause) mcause <= csr_new;
      end
    end
  end

endmodule

// File: tb/tb_gpr_csr_file.sv
// Randomized scoreboard bench for gpr_csr_file.
// Two instances (bypass on/off) share stimulus.
module tb_gpr_csr_file;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wen;
  logic [4:0]    waddr;
  logic [31:0]   wdata;
  logic [9:0]    raddr;
  logic [1:0]    csr_op;
  logic [11:0]   csr_addr;
  logic [31:0]   csr_wdata;
  logic          retire, trap_valid, mret;
  logic [31:0]   trap_cause, trap_pc;

  logic [63:0]   rd_b, rd_n;
  logic [31:0]   crd_b, crd_n, mtv_b, mtv_n, mep_b, mep_n;
  logic          ill_b, ill_n;
  logic [1023:0] dbg_b, dbg_n;

  always #5 clk = ~clk;

  gpr_csr_file #(.BYPASS(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rd_b), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(crd_b), .csr_illegal(ill_b),
    .retire(retire), .trap_valid(trap_valid), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .mret(mret), .mtvec_o(mtv_b), .mepc_o(mep_b),
    .dbg_x(dbg_b)
  );

  gpr_csr_file #(.BYPASS(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rd_n), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(crd_n), .csr_illegal(ill_n),
    .retire(retire), .trap_valid(trap_valid), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .mret(mret), .mtvec_o(mtv_n), .mepc_o(mep_n),
    .dbg_x(dbg_n)
  );

  // reference model
  logic [31:0] x [32];
  bit          known [32];
  bit          m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mscratch;
  logic [63:0] m_cyc, m_ins;
  int          dbg_k;

  typedef struct {
    logic [1:0][31:0] rdb;
    logic [1:0][31:0] rdn;
    bit   [1:0]       chkb;
    bit   [1:0]       chkn;
    logic [31:0]      crd;
    logic             ill;
    logic [31:0]      mtv;
    logic [31:0]      mep;
    int               k;
    logic [31:0]      dbg;
    bit               dchk;
  } exp_t;

  exp_t q [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [11:0] addrs [14] = '{12'h300, 12'h305, 12'h340, 12'h341,
    12'h342, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF11, 12'hF12,
    12'h7C0, 12'h301, 12'hC00};

  task automatic model_reset();
    m_mie = 0; m_mpie = 0;
    m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mscratch = 0;
    m_cyc = 0; m_ins = 0;
  endtask

  function automatic void m_read(input logic [11:0] a,
                                 output bit hit, output logic [31:0] v);
    hit = 1;
    case (a)
      12'h300: v = 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'hB00: v = m_cyc[31:0];
      12'hB80: v = m_cyc[63:32];
      12'hB02: v = m_ins[31:0];
      12'hB82: v = m_ins[63:32];
      12'hF11: v = 32'h79737978;
      12'hF12: v = 32'h017eb18f;
      default: begin hit = 0; v = 0; end
    endcase
  endfunction

  function automatic void m_eval(output logic [31:0] v, output bit ill,
                                 output bit wr, output logic [31:0] nv);
    bit hit, we;
    m_read(csr_addr, hit, v);
    we  = (csr_op == 2'b01) || (csr_op[1] && csr_wdata != 0);
    ill = (csr_op != 0) &&
          (!hit || (we && (csr_addr == 12'hF11 || csr_addr == 12'hF12)));
    wr  = we && !ill;
    if (csr_op == 2'b10)      nv = v | csr_wdata;
    else if (csr_op == 2'b11) nv = v & ~csr_wdata;
    else                      nv = csr_wdata;
  endfunction

  task automatic commit();
    logic [31:0] v, nv;
    bit ill, wr;
    m_eval(v, ill, wr, nv);
    if (wen && waddr != 0) begin
      x[waddr] = wdata;
      known[waddr] = 1;
    end
    if (wr && csr_addr == 12'hB00)      m_cyc[31:0] = nv;
    else if (wr && csr_addr == 12'hB80) m_cyc[63:32] = nv;
    else                                m_cyc = m_cyc + 1;
    if (wr && csr_addr == 12'hB02)      m_ins[31:0] = nv;
    else if (wr && csr_addr == 12'hB82) m_ins[63:32] = nv;
    else if (retire)                    m_ins = m_ins + 1;
    if (wr && csr_addr == 12'h305) m_mtvec = nv & ~32'h3;
    if (wr && csr_addr == 12'h340) m_mscratch = nv;
    if (trap_valid) begin
      m_mepc = trap_pc & ~32'h3;
      m_mcause = trap_cause;
      m_mpie = m_mie;
      m_mie = 0;
    end else if (mret) begin
      m_mie = m_mpie;
      m_mpie = 1;
    end else if (wr) begin
      if (csr_addr == 12'h300) begin
        m_mie = nv[3];
        m_mpie = nv[7];
      end
      if (csr_addr == 12'h341) m_mepc = nv & ~32'h3;
      if (csr_addr == 12'h342) m_mcause = nv;
    end
  endtask

  task automatic set_idle();
    wen = 0; waddr = 0; wdata = 0; raddr = 0;
    csr_op = 0; csr_addr = 0; csr_wdata = 0;
    retire = 0; trap_valid = 0; mret = 0;
    trap_cause = 0; trap_pc = 0;
    dbg_k = $urandom_range(0, 31);
  endtask

  task automatic begin_cycle();
    @(posedge clk);
    if (rst_n) commit();
    #1;
    set_idle();
  endtask

  task automatic issue();
    exp_t e;
    logic [31:0] v, nv;
    bit ill, wr;
    logic [4:0] ra;
    m_eval(v, ill, wr, nv);
    for (int p = 0; p < 2; p++) begin
      ra = raddr[p*5 +: 5];
      e.rdn[p]  = (ra == 0) ? 32'h0 : x[ra];
      e.chkn[p] = (ra == 0) || known[ra];
      if (ra != 0 && wen && waddr == ra) begin
        e.rdb[p]  = wdata;
        e.chkb[p] = 1;
      end else begin
        e.rdb[p]  = e.rdn[p];
        e.chkb[p] = e.chkn[p];
      end
    end
    e.crd  = (csr_op != 0) ? v : 32'h0;
    e.ill  = ill;
    e.mtv  = m_mtvec;
    e.mep  = m_mepc;
    e.k    = dbg_k;
    e.dbg  = (dbg_k == 0) ? 32'h0 : x[dbg_k];
    e.dchk = (dbg_k == 0) || known[dbg_k];
    q.push_back(e);
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a,
                     input logic [31:0] w);
    csr_op = op; csr_addr = a; csr_wdata = w;
  endtask

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", n, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      for (int p = 0; p < 2; p++) begin
        if (e.chkb[p]) chk("rdata_byp", rd_b[p*32 +: 32], e.rdb[p]);
        if (e.chkn[p]) chk("rdata_nobyp", rd_n[p*32 +: 32], e.rdn[p]);
      end
      chk("csr_rdata", crd_b, e.crd);
      chk("csr_rdata_n", crd_n, e.crd);
      chk("csr_illegal", 32'(ill_b), 32'(e.ill));
      chk("csr_illegal_n", 32'(ill_n), 32'(e.ill));
      chk("mtvec_o", mtv_b, e.mtv);
      chk("mepc_o", mep_b, e.mep);
      chk("mepc_o_n", mep_n, e.mep);
      chk("mtvec_o_n", mtv_n, e.mtv);
      if (e.dchk) begin
        chk("dbg_x", dbg_b[e.k*32 +: 32], e.dbg);
        chk("dbg_x_n", dbg_n[e.k*32 +: 32], e.dbg);
      end
    end
  end

  initial begin
    rst_n = 0;
    set_idle();
    model_reset();
    for (int i = 0; i < 32; i++) begin
      x[i] = 0;
      known[i] = (i == 0);
    end
    #12 rst_n = 1;

    // reset state with csr_op idle, then mcycle count
    begin_cycle(); issue();
    begin_cycle(); csr(2'b10, 12'hB00, 0); issue();
    begin_cycle(); csr(2'b10, 12'h300, 0); issue();

    // fill GPRs, reading the written index for bypass
    for (int r = 1; r < 32; r++) begin
      begin_cycle();
      wen = 1; waddr = 5'(r); wdata = $urandom;
      raddr = {5'(r - 1), 5'(r)};
      issue();
    end

    begin_cycle(); wen = 1; waddr = 5; wdata = 32'hDEADBEEF; issue();
    begin_cycle(); raddr = {5'd5, 5'd5}; dbg_k = 5; issue();
    begin_cycle(); wen = 1; waddr = 0; wdata = 1; issue();
    begin_cycle(); raddr = {5'd0, 5'd0}; dbg_k = 0; issue();
    begin_cycle();
    wen = 1; waddr = 7; wdata = 32'h1234; raddr = {5'd5, 5'd7};
    issue();

    // counter half writes and wrap
    begin_cycle(); csr(2'b01, 12'hB80, 0); issue();
    begin_cycle(); csr(2'b01, 12'hB00, 32'hFFFFFFFF); issue();
    begin_cycle(); csr(2'b10, 12'hB80, 0); issue();
    begin_cycle(); csr(2'b10, 12'hB00, 0); issue();
    begin_cycle(); csr(2'b01, 12'hB80, 32'hFFFFFFFF); issue();
    begin_cycle(); csr(2'b01, 12'hB00, 32'hFFFFFFFF); issue();
    begin_cycle(); csr(2'b10, 12'hB00, 0); issue();
    begin_cycle(); csr(2'b10, 12'hB80, 0); issue();
    begin_cycle(); csr(2'b01, 12'hB00, 32'h10); issue();
    begin_cycle(); csr(2'b10, 12'hB00, 0); issue();
    begin_cycle(); csr(2'b10, 12'hB00, 0); issue();

    // trap / mret
    begin_cycle(); csr(2'b10, 12'h300, 32'h8); issue();
    begin_cycle();
    trap_valid = 1; trap_cause = 32'hB; trap_pc = 32'h80000100;
    csr(2'b10, 12'h300, 0);
    issue();
    begin_cycle(); csr(2'b10, 12'h342, 0); issue();
    begin_cycle(); csr(2'b10, 12'h300, 0); mret = 1; issue();
    begin_cycle(); csr(2'b10, 12'h300, 0); issue();

    // illegal and read-only accesses
    begin_cycle(); csr(2'b01, 12'hF11, 32'h5); issue();
    begin_cycle(); csr(2'b10, 12'hF11, 0); issue();
    begin_cycle(); csr(2'b10, 12'hF12, 0); issue();
    begin_cycle(); csr(2'b10, 12'h7C0, 0); issue();

    // same-edge trap beats mepc write
    begin_cycle();
    csr(2'b01, 12'h341, 32'h40);
    trap_valid = 1; trap_cause = 32'h2; trap_pc = 32'h80000204;
    issue();
    begin_cycle(); csr(2'b10, 12'h341, 0); issue();

    // asynchronous reset pulse inside a cycle
    begin_cycle(); csr(2'b10, 12'h300, 32'h88); issue();
    begin_cycle();
    csr(2'b10, 12'h300, 0);
    #2 rst_n = 0;
    model_reset();
    #1 rst_n = 1;
    issue();
    begin_cycle(); csr(2'b10, 12'hB00, 0); issue();

    for (int n = 0; n < 700; n++) begin
      begin_cycle();
      wen = 1'($urandom); waddr = 5'($urandom); wdata = $urandom;
      raddr[4:0] = $urandom_range(0, 1) == 1 ? waddr : 5'($urandom);
      raddr[9:5] = 5'($urandom);
      csr_op = 2'($urandom);
      csr_addr = addrs[$urandom_range(0, 13)];
      csr_wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      retire = 1'($urandom);
      trap_valid = $urandom_range(0, 7) == 0;
      trap_cause = $urandom; trap_pc = $urandom;
      mret = $urandom_range(0, 7) == 0;
      issue();
    end

    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
